mips_fetch_regs: RTL and testbench
==================================

# mips_fetch_regs

Non-architectural register bank and PC-update logic of the multicycle MIPS datapath, sitting directly downstream of the `controle` unit. Holds PC, instruction register (IR), memory data register and ALUOut. Consumes the control unit's PC/IR/branch signals and feeds `opcode`/`funct` back to it. Also produces the memory address (PC vs ALUOut) and the decoded instruction fields used by the register file and ALU.

## Interface
Parameters:
- `RESET_PC`: default 32'h0000_0000. PC value loaded on reset.

Ports:
- `clk`: in, 1. Single clock, rising edge.
- `rst`: in, 1. Reset is synchronous and active-high.
- `PCWrite`: in, 1. Unconditional PC write, from control.
- `Branch`: in, 1. Branch-if-equal enable.
- `BranchNE`: in, 1. Branch-if-not-equal enable.
- `IRWrite`: in, 1. Latch `ReadData` into IR.
- `IorD`: in, 1. Address select: 0 = PC, 1 = ALUOut.
- `PCSrc`: in, 2. Next-PC source select.
- `ALUResult`: in, 32. Current ALU output.
- `Zero`: in, 1. ALU zero flag.
- `ReadData`: in, 32. Memory read data.
- `pc`: out, 32. Current PC.
- `Adr`: out, 32. Memory address.
- `instr`: out, 32. IR contents.
- `opcode`: out, 6. `instr[31:26]`, to control.
- `funct`: out, 6. `instr[5:0]`, to control.
- `rs`, `rt`, `rd`: out, 5 each. `instr[25:21]`, `[20:16]`, `[15:11]`.
- `SignImm`: out, 32. `instr[15:0]` sign-extended.
- `Data`: out, 32. Memory data register.
- `ALUOut`: out, 32. Registered ALU result.
- `PCEn`: out, 1. Effective PC write enable.
- `fetch_count`: out, 32. Number of instruction fetches (see Configuration).

## Operation
- `PCEn = PCWrite | (Branch & Zero) | (BranchNE & ~Zero)`. This is combinational.
- Next PC, written on a rising edge when `PCEn`=1, selected by `PCSrc`:
  - 00: `ALUResult`.
  - 01: `ALUOut`.
  - 10: jump target `{pc[31:28], instr[25:0], 2'b00}`, using the pre-edge `pc` and `instr`.
  - 11: reserved; PC holds even if `PCEn`=1.
- IR loads `ReadData` on an edge when `IRWrite`=1; otherwise it holds.
- `Data` loads `ReadData` every cycle.
- `ALUOut` loads `ALUResult` every cycle.
- `Adr = IorD ? ALUOut : pc`. This is combinational.
- Decoded fields (`opcode`, `funct`, `rs`, `rt`, `rd`, `SignImm`) are pure combinational slices of `instr`.
- Simultaneous `IRWrite` and `PCEn` (the fetch cycle): both registers update on the same edge. Any jump computed that edge uses the old `instr`.
- `Branch` and `BranchNE` both high: the OR rule applies, so `PCEn`=1 regardless of `Zero`.

## Timing
- Reset values on the edge with `rst`=1:
  - `pc`=`RESET_PC`; `instr`=0, so `opcode`=0 and `funct`=0; `Data`=0; `ALUOut`=0; `fetch_count`=0.
- `rst` overrides every enable on that edge, including reset asserted mid-instruction.
- Register outputs change only on the rising edge of `clk`, one cycle after their enable is sampled.
- `Adr`, `PCEn` and the decoded fields have zero-cycle latency from their inputs or registers.

## Configuration
- Macro `FETCH_CNT_EN`.
- Defined:
  - `fetch_count` increments by 1 on every edge with `IRWrite`=1 and `rst`=0.
  - It wraps from 32'hFFFF_FFFF to 0.
- Undefined: the counter logic is absent and `fetch_count` is tied to 32'h0. The port list is identical in both builds.

## Structure
- Shared package `mips_pkg`:
  - `pcsrc_t` enum: `PCSRC_ALU`=2'b00, `PCSRC_ALUOUT`=2'b01, `PCSRC_JUMP`=2'b10.
  - Opcode constants: R-type 6'b000000, LW 6'b100011, SW 6'b101011, BEQ 6'b000100, BNE 6'b000101, ADDI 6'b001000, J 6'b000010.
  - Word-width constant 32.
- One sub-module, `flopenr`: parameterised-width register with synchronous active-high reset, enable and reset value. It is instantiated for PC, IR, Data and ALUOut, with enable tied 1 for the last two.

## Test plan
- **Reset:** hold `rst`=1 with `PCWrite`=1, `ALUResult`=32'h40.
  -> `pc`=`RESET_PC`, `instr`=0, `ALUOut`=0, `fetch_count`=0.
- **Fetch:** `pc`=0, `ReadData`=32'h2008_0005, `IRWrite`=1, `PCWrite`=1, `PCSrc`=00, `ALUResult`=4.
  -> next cycle: `pc`=4, `opcode`=6'b001000, `rt`=8, `SignImm`=5, `fetch_count`=1 (macro on).
- **BEQ / BNE:** `Branch`=1, `Zero`=1, `PCSrc`=01, `ALUOut`=32'h20 -> `pc`=32'h20.
  - Repeat with `Zero`=0 -> `PCEn`=0, `pc` holds.
  - `BranchNE`=1, `Zero`=0 -> `pc`=32'h20.
- **Jump:** `pc`=32'h1000_0004, `instr`=32'h0800_0010, `PCWrite`=1, `PCSrc`=10
  -> `pc`=32'h1000_0040.
- **Address mux / sign extension:** `ALUOut`=32'h44, `IorD`=1 -> `Adr`=32'h44.
  - `instr[15:0]`=16'hFFFC -> `SignImm`=32'hFFFF_FFFC.
- **Counter wrap and PCSrc 11:** with `fetch_count` at 32'hFFFF_FFFF, one `IRWrite` -> 0.
  - `PCSrc`=11, `PCWrite`=1 -> `pc` unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared types and constants for the multicycle MIPS datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

endpackage

`default_nettype wire

// File: rtl/flopenr.sv
// ============================================================================
// Module : flopenr
// Brief  : Enabled register with synchronous active-high reset to RESET_VAL.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flopenr #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VAL;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/mips_fetch_regs.sv
// ============================================================================
// Module : mips_fetch_regs
// Brief  : PC/IR/Data/ALUOut register bank with next-PC logic and decode.
//          Optional fetch counter enabled by macro FETCH_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_fetch_regs
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        Branch,
    input  logic        BranchNE,
    input  logic        IRWrite,
    input  logic        IorD,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ALUResult,
    input  logic        Zero,
    input  logic [31:0] ReadData,
    output logic [31:0] pc,
    output logic [31:0] Adr,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] SignImm,
    output logic [31:0] Data,
    output logic [31:0] ALUOut,
    output logic        PCEn,
    output logic [31:0] fetch_count
);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;
    logic [WORD_W-1:0] instr_q;
    logic [WORD_W-1:0] data_q;
    logic [WORD_W-1:0] aluout_q;

    assign PCEn = PCWrite | (Branch & Zero) | (BranchNE & ~Zero);

    // Reserved select feeds the current PC back so the write is a no-op.
    always_comb begin
        pc_d = pc_q;
        case (pcsrc_t'(PCSrc))
            PCSRC_ALU:    pc_d = ALUResult;
            PCSRC_ALUOUT: pc_d = aluout_q;
            PCSRC_JUMP:   pc_d = {pc_q[31:28], instr_q[25:0], 2'b00};
            default:      pc_d = pc_q;
        endcase
    end

    flopenr #(.WIDTH(WORD_W), .RESET_VAL(RESET_PC)) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (PCEn),
        .d_i  (pc_d),
        .q_o  (pc_q)
    );

    flopenr #(.WIDTH(WORD_W), .RESET_VAL('0)) u_ir_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (IRWrite),
        .d_i  (ReadData),
        .q_o  (instr_q)
    );

    flopenr #(.WIDTH(WORD_W), .RESET_VAL('0)) u_data_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (1'b1),
        .d_i  (ReadData),
        .q_o  (data_q)
    );

    flopenr #(.WIDTH(WORD_W), .RESET_VAL('0)) u_aluout_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (1'b1),
        .d_i  (ALUResult),
        .q_o  (aluout_q)
    );

    assign pc      = pc_q;
    assign instr   = instr_q;
    assign Data    = data_q;
    assign ALUOut  = aluout_q;
    assign Adr     = IorD ? aluout_q : pc_q;

    assign opcode  = instr_q[31:26];
    assign rs      = instr_q[25:21];
    assign rt      = instr_q[20:16];
    assign rd      = instr_q[15:11];
    assign funct   = instr_q[5:0];
    assign SignImm = {{16{instr_q[15]}}, instr_q[15:0]};

`ifdef FETCH_CNT_EN
    logic [WORD_W-1:0] fcnt_q;
    logic [WORD_W-1:0] fcnt_d;

    assign fcnt_d = fcnt_q + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q <= '0;
        end else if (IRWrite) begin
            fcnt_q <= fcnt_d;
        end
    end

    assign fetch_count = fcnt_q;
`else
    assign fetch_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_fetch_regs.sv
// ============================================================================
// Module : tb_mips_fetch_regs
// Brief  : Directed and random checks of mips_fetch_regs against a reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_fetch_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite, Branch, BranchNE, IRWrite, IorD, Zero;
    logic [1:0]  PCSrc;
    logic [31:0] ALUResult, ReadData;
    logic [31:0] pc, Adr, instr, SignImm, Data, ALUOut, fetch_count;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic        PCEn;

    mips_fetch_regs dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .Branch(Branch), .BranchNE(BranchNE),
        .IRWrite(IRWrite), .IorD(IorD), .PCSrc(PCSrc), .ALUResult(ALUResult),
        .Zero(Zero), .ReadData(ReadData), .pc(pc), .Adr(Adr), .instr(instr),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .SignImm(SignImm),
        .Data(Data), .ALUOut(ALUOut), .PCEn(PCEn), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit model_valid = 1'b0;

    // Reference state
    logic [31:0] m_pc, m_instr, m_data, m_aluout, m_cnt;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic drive(input logic r, input logic pw, input logic br, input logic bne,
                         input logic irw, input logic iord, input logic [1:0] src,
                         input logic [31:0] alu, input logic z, input logic [31:0] rdat);
        rst = r; PCWrite = pw; Branch = br; BranchNE = bne; IRWrite = irw;
        IorD = iord; PCSrc = src; ALUResult = alu; Zero = z; ReadData = rdat;
    endtask

    // Compare every output to the model mid-cycle, then advance the model across the edge.
    task automatic cycle();
        logic        en;
        logic [31:0] npc;
        #2;
        en = PCWrite | (Branch & Zero) | (BranchNE & !Zero);
        if (model_valid) begin
            chk("pc", pc, m_pc);
            chk("instr", instr, m_instr);
            chk("Data", Data, m_data);
            chk("ALUOut", ALUOut, m_aluout);
            chk("Adr", Adr, IorD ? m_aluout : m_pc);
            chk("opcode", 32'(opcode), 32'(m_instr >> 26));
            chk("funct", 32'(funct), m_instr % 64);
            chk("rs", 32'(rs), (m_instr >> 21) % 32);
            chk("rt", 32'(rt), (m_instr >> 16) % 32);
            chk("rd", 32'(rd), (m_instr >> 11) % 32);
            chk("SignImm", SignImm, 32'($signed(m_instr[15:0])));
            chk("PCEn", 32'(PCEn), 32'(en));
            chk("fetch_count", fetch_count, m_cnt);
        end
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_data = 32'h0; m_aluout = 32'h0; m_cnt = 32'h0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            npc = m_pc;
            if (en) begin
                if (PCSrc == 2'd0)      npc = ALUResult;
                else if (PCSrc == 2'd1) npc = m_aluout;
                else if (PCSrc == 2'd2) npc = (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
            end
            m_pc = npc;
            if (IRWrite) begin
                m_instr = ReadData;
`ifdef FETCH_CNT_EN
                m_cnt = m_cnt + 32'd1;
`endif
            end
            m_data = ReadData;
            m_aluout = ALUResult;
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_cnt;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 2'd0, 32'h0, 0, 32'h0);
        @(posedge clk); #1;

        // Reset overrides enables
        drive(1, 1, 0, 0, 1, 0, 2'd0, 32'h40, 0, 32'hDEAD_BEEF);
        cycle(); cycle();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_aluout", ALUOut, 32'h0);
        chk("rst_data", Data, 32'h0);
        chk("rst_fcnt", fetch_count, 32'h0);

        // Fetch: addi $t0,$zero,5
        drive(0, 1, 0, 0, 1, 0, 2'd0, 32'h4, 0, 32'h2008_0005);
        cycle();
        chk("fetch_pc", pc, 32'h4);
        chk("fetch_opcode", 32'(opcode), 32'h08);
        chk("fetch_rt", 32'(rt), 32'd8);
        chk("fetch_signimm", SignImm, 32'h5);
`ifdef FETCH_CNT_EN
        exp_cnt = 32'd1;
`else
        exp_cnt = 32'd0;
`endif
        chk("fetch_fcnt", fetch_count, exp_cnt);

        // BEQ not taken then taken
        drive(0, 1, 0, 0, 0, 0, 2'd0, 32'h8, 0, 32'h0);     cycle();
        drive(0, 0, 0, 0, 0, 0, 2'd0, 32'h20, 0, 32'h0);    cycle();
        drive(0, 0, 1, 0, 0, 0, 2'd1, 32'h20, 0, 32'h0);    #1;
        chk("beq_nt_pcen", 32'(PCEn), 32'd0);
        cycle();
        chk("beq_nt_pc", pc, 32'h8);
        drive(0, 0, 1, 0, 0, 0, 2'd1, 32'h20, 1, 32'h0);    cycle();
        chk("beq_t_pc", pc, 32'h20);

        // BNE taken
        drive(0, 1, 0, 0, 0, 0, 2'd0, 32'h8, 0, 32'h0);     cycle();
        drive(0, 0, 0, 0, 0, 0, 2'd0, 32'h20, 0, 32'h0);    cycle();
        drive(0, 0, 0, 1, 0, 0, 2'd1, 32'h20, 0, 32'h0);    cycle();
        chk("bne_t_pc", pc, 32'h20);
        drive(0, 0, 1, 1, 0, 1, 2'd1, 32'h44, 1, 32'h0);    #1;
        chk("both_br_pcen", 32'(PCEn), 32'd1);
        cycle();

        // Address mux
        drive(0, 0, 0, 0, 0, 1, 2'd0, 32'h0, 0, 32'h0);     #1;
        chk("adr_aluout", Adr, 32'h44);
        cycle();

        // Jump
        drive(0, 1, 0, 0, 1, 0, 2'd0, 32'h1000_0004, 0, 32'h0800_0010); cycle();
        drive(0, 1, 0, 0, 0, 0, 2'd2, 32'h0, 0, 32'h0);     cycle();
        chk("jump_pc", pc, 32'h1000_0040);

        // Sign extension and reserved PCSrc
        drive(0, 0, 0, 0, 1, 0, 2'd0, 32'h0, 0, 32'h8C08_FFFC); cycle();
        chk("signimm_neg", SignImm, 32'hFFFF_FFFC);
        drive(0, 1, 0, 0, 0, 0, 2'd3, 32'h1234, 0, 32'h0);  cycle();
        chk("pcsrc11_pc", pc, 32'h1000_0040);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 32) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 2'($urandom), $urandom, 1'($urandom), $urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
